// File: rtl/game_pkg.sv
// Shared types and helpers for the round controller: FSM state encoding,
// level constants and the level-to-window mapping.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_SPAWN     = 3'd2,
    ST_ACTIVE    = 3'd3,
    ST_SCORE     = 3'd4,
    ST_GAP       = 3'd5,
    ST_GAME_OVER = 3'd6
  } round_state_t;

  localparam logic [1:0] LVL1 = 2'd1;
  localparam logic [1:0] LVL2 = 2'd2;
  localparam logic [1:0] LVL3 = 2'd3;

  localparam logic [9:0] SCORE_MAX = 10'd999;

  // Level 0 is not a legal selector output; treat it as level 1.
  function automatic logic [1:0] norm_level(input logic [1:0] lvl);
    return (lvl == 2'd0) ? LVL1 : lvl;
  endfunction

  // Window lengths are parameters of the top, so they are passed in.
  function automatic logic [11:0] win_ms(input logic [1:0]  lvl,
                                         input logic [11:0] w1,
                                         input logic [11:0] w2,
                                         input logic [11:0] w3);
    case (lvl)
      LVL2:    return w2;
      LVL3:    return w3;
      default: return w1;
    endcase
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond down-timer: a clock prescaler feeding a 12-bit ms counter.
// A load restarts the prescaler at 0, so a load of N ms expires exactly
// N*CLKS_PER_MS cycles later. `expired` is high for the last cycle only.
module ms_timer #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] load_ms,
  output logic        expired,
  output logic [11:0] ms_left
);

  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_MS - 1);

  logic [PW-1:0] pre_q;
  logic          tick;

  assign tick    = (pre_q == PRE_LAST) && (ms_left != 12'd0);
  assign expired = tick && (ms_left == 12'd1);

  // Prescaler and ms counter; the counter parks at 0 once run out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      ms_left <= 12'd0;
    end else if (load) begin
      pre_q   <= '0;
      ms_left <= load_ms;
    end else if (ms_left != 12'd0) begin
      if (tick) begin
        pre_q   <= '0;
        ms_left <= ms_left - 12'd1;
      end else begin
        pre_q <= pre_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/round_controller.sv
// Game-round sequencer: countdown, target spawn, timed response window,
// level-weighted scoring and miss counting, game end on round/miss limit.
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | waiting for start, counters cleared
// COUNTDOWN  | pre-game countdown running
// SPAWN      | one cycle, target presented, window timer loaded
// ACTIVE     | response window open, waiting for hit or expiry
// SCORE      | one cycle, round counted, end-of-game decision
// GAP        | idle gap between rounds
// GAME_OVER  | results held until the next start
module round_controller
  import game_pkg::*;
#(
  parameter int CLKS_PER_MS  = 50000,
  parameter int COUNTDOWN_MS = 3000,
  parameter int GAP_MS       = 500,
  parameter int WIN_L1_MS    = 2000,
  parameter int WIN_L2_MS    = 1200,
  parameter int WIN_L3_MS    = 700,
  parameter int ROUNDS       = 10,
  parameter int MAX_MISSES   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  level,
  input  logic        level_reset,
  input  logic        start,
  input  logic        hit,
  output logic        spawn,
  output logic        round_active,
  output logic        game_over,
  output logic [9:0]  score,
  output logic [3:0]  misses,
  output logic [4:0]  round_num,
  output logic [11:0] time_left_ms,
  output logic [2:0]  state
);

  round_state_t state_q, state_d;
  logic [1:0]   lvl_q;
  logic [9:0]   score_q;
  logic [3:0]   misses_q;
  logic [4:0]   round_q;
  logic [10:0]  score_sum;
  logic         game_end;

  logic         tmr_load;
  logic [11:0]  tmr_load_ms;
  logic         tmr_expired;
  logic [11:0]  tmr_ms_left;

  ms_timer #(
    .CLKS_PER_MS (CLKS_PER_MS)
  ) u_ms_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_ms (tmr_load_ms),
    .expired (tmr_expired),
    .ms_left (tmr_ms_left)
  );

  assign score_sum = {1'b0, score_q} + {9'd0, lvl_q};
  assign game_end  = (misses_q == 4'(MAX_MISSES)) ||
                     ((round_q + 5'd1) == 5'(ROUNDS));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; level_reset overrides every other event
  always_comb begin
    state_d = state_q;
    if (level_reset) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_GAME_OVER: if (start) state_d = ST_COUNTDOWN;
        ST_COUNTDOWN:          if (tmr_expired) state_d = ST_SPAWN;
        ST_SPAWN:              state_d = ST_ACTIVE;
        ST_ACTIVE:             if (hit || tmr_expired) state_d = ST_SCORE;
        ST_SCORE:              state_d = game_end ? ST_GAME_OVER : ST_GAP;
        ST_GAP:                if (tmr_expired) state_d = ST_SPAWN;
        default:               state_d = ST_IDLE;
      endcase
    end
  end

  // Timer is restarted on every state change with the length of the new phase
  always_comb begin
    tmr_load    = (state_d != state_q);
    tmr_load_ms = 12'd0;
    case (state_d)
      ST_COUNTDOWN: tmr_load_ms = 12'(COUNTDOWN_MS);
      ST_ACTIVE:    tmr_load_ms = win_ms(lvl_q, 12'(WIN_L1_MS),
                                         12'(WIN_L2_MS), 12'(WIN_L3_MS));
      ST_GAP:       tmr_load_ms = 12'(GAP_MS);
      default:      tmr_load_ms = 12'd0;
    endcase
  end

  // Latched level, score, misses and completed-round counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q    <= LVL1;
      score_q  <= 10'd0;
      misses_q <= 4'd0;
      round_q  <= 5'd0;
    end else if (level_reset) begin
      score_q  <= 10'd0;
      misses_q <= 4'd0;
      round_q  <= 5'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_GAME_OVER: begin
          if (start) begin
            lvl_q    <= norm_level(level);
            score_q  <= 10'd0;
            misses_q <= 4'd0;
            round_q  <= 5'd0;
          end
        end
        ST_ACTIVE: begin
          if (hit) begin
            score_q <= (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[9:0];
          end else if (tmr_expired) begin
            misses_q <= misses_q + 4'd1;
          end
        end
        ST_SCORE: round_q <= round_q + 5'd1;
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    spawn        = (state_q == ST_SPAWN);
    round_active = (state_q == ST_ACTIVE);
    game_over    = (state_q == ST_GAME_OVER);
    score        = score_q;
    misses       = misses_q;
    round_num    = round_q;
    state        = state_q;
    time_left_ms = 12'd0;
    if (state_q == ST_COUNTDOWN || state_q == ST_ACTIVE || state_q == ST_GAP)
      time_left_ms = tmr_ms_left;
  end

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller using a game-level reference
// model: expected phase lengths, scores and misses come from ms counts and
// per-round hit/miss decisions, not from a cycle-level state machine.
module tb_round_controller;

   localparam int CPM = 4, CD_MS = 3, GAP_MS = 2;
   localparam int W1 = 5, W2 = 3, W3 = 2;
   localparam int ROUNDS = 4, MAXM = 2;
   localparam logic [2:0] S_IDLE = 3'd0, S_COUNTDOWN = 3'd1, S_GAP = 3'd5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  level = 2'd1;
   logic        level_reset = 1'b0, start = 1'b0, hit = 1'b0;
   logic        spawn, round_active, game_over;
   logic [9:0]  score;
   logic [3:0]  misses;
   logic [4:0]  round_num;
   logic [11:0] time_left_ms;
   logic [2:0]  state;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   round_controller #(
      .CLKS_PER_MS(CPM), .COUNTDOWN_MS(CD_MS), .GAP_MS(GAP_MS),
      .WIN_L1_MS(W1), .WIN_L2_MS(W2), .WIN_L3_MS(W3),
      .ROUNDS(ROUNDS), .MAX_MISSES(MAXM)
   ) dut (
      .clk(clk), .rst(rst), .level(level), .level_reset(level_reset),
      .start(start), .hit(hit), .spawn(spawn), .round_active(round_active),
      .game_over(game_over), .score(score), .misses(misses),
      .round_num(round_num), .time_left_ms(time_left_ms), .state(state)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Counts cycles until spawn is seen (bounded); optional stray pulses.
   task automatic wait_spawn(input bit stray, output int n);
      n = 0;
      while (spawn !== 1'b1 && n < 200) begin
         if (stray && n == 3) hit = 1'b1;
         if (stray && n == 5) start = 1'b1;
         tick;
         hit = 1'b0;
         start = 1'b0;
         n++;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({state, spawn, round_active, game_over, score, misses, round_num, time_left_ms} !== '0) begin
         $display("FAIL reset_async: outputs %h want 0",
                  {state, spawn, round_active, game_over, score, misses, round_num, time_left_ms});
         n_err++;
      end
      @(negedge clk) rst = 1'b0;
      tick;
      n_cmp++;
      if (state !== S_IDLE || time_left_ms !== 12'd0) begin
         $display("FAIL reset_idle: state %0d tl %0d want %0d 0", state, time_left_ms, S_IDLE);
         n_err++;
      end
   endtask

   // mode: -1 random hit/miss, -2 never hit, >=0 hit at that ACTIVE offset (clamped)
   task automatic play_game(input int lvl_in, input int mode, input bit chg, input bit stray);
      int L, WMS, W, off, n, e_score, e_miss, e_rnd;
      bit do_hit;
      L   = (lvl_in == 0) ? 1 : lvl_in;
      WMS = (L == 3) ? W3 : (L == 2) ? W2 : W1;
      W   = WMS * CPM;
      e_score = 0; e_miss = 0; e_rnd = 0;
      level = 2'(lvl_in);
      start = 1'b1;
      tick;
      start = 1'b0;
      n_cmp++;
      if ({state, time_left_ms, score, misses, round_num, game_over} !==
          {S_COUNTDOWN, 12'(CD_MS), 10'd0, 4'd0, 5'd0, 1'b0}) begin
         $display("FAIL start_entry: state %0d tl %0d sc %0d mi %0d rn %0d go %0d",
                  state, time_left_ms, score, misses, round_num, game_over);
         n_err++;
      end
      if (chg) level = 2'd3;
      wait_spawn(stray, n);
      n_cmp++;
      if (n !== CD_MS * CPM) begin
         $display("FAIL countdown_len: got %0d cycles want %0d", n, CD_MS * CPM);
         n_err++;
      end
      n_cmp++;
      if (time_left_ms !== 12'd0) begin
         $display("FAIL spawn_time_left: got %0d want 0", time_left_ms);
         n_err++;
      end
      for (int r = 0; r < ROUNDS; r++) begin
         tick;
         n_cmp++;
         if ({round_active, time_left_ms} !== {1'b1, 12'(WMS)}) begin
            $display("FAIL active_entry: ra %0d tl %0d want 1 %0d", round_active, time_left_ms, WMS);
            n_err++;
         end
         if (mode == -2) do_hit = 1'b0;
         else if (mode == -1) do_hit = ($urandom_range(0, 3) != 0);
         else do_hit = 1'b1;
         off = (mode >= 0) ? ((mode > W - 1) ? W - 1 : mode) : int'($urandom_range(0, W - 1));
         if (do_hit) begin
            repeat (off) tick;
            hit = 1'b1;
            tick;
            hit = 1'b0;
            e_score += L;
         end else begin
            repeat (W - 1) tick;
            n_cmp++;
            if (round_active !== 1'b1) begin
               $display("FAIL window_len: round_active %0d at cycle %0d want 1", round_active, W - 1);
               n_err++;
            end
            tick;
            e_miss++;
         end
         n_cmp++;
         if ({round_active, score, misses, time_left_ms} !==
             {1'b0, 10'(e_score), 4'(e_miss), 12'd0}) begin
            $display("FAIL round_result: ra %0d sc %0d mi %0d tl %0d want 0 %0d %0d 0",
                     round_active, score, misses, time_left_ms, e_score, e_miss);
            n_err++;
         end
         e_rnd++;
         if (e_miss == MAXM || e_rnd == ROUNDS) begin
            tick;
            hit = 1'b1;
            tick;
            hit = 1'b0;
            tick;
            n_cmp++;
            if ({game_over, round_active, spawn, score, misses, round_num, time_left_ms} !==
                {3'b100, 10'(e_score), 4'(e_miss), 5'(e_rnd), 12'd0}) begin
               $display("FAIL game_over: go %0d ra %0d sp %0d sc %0d mi %0d rn %0d tl %0d want 1 0 0 %0d %0d %0d 0",
                        game_over, round_active, spawn, score, misses, round_num, time_left_ms,
                        e_score, e_miss, e_rnd);
               n_err++;
            end
            break;
         end
         wait_spawn(1'b0, n);
         n_cmp++;
         if (n !== 1 + GAP_MS * CPM || round_num !== 5'(e_rnd)) begin
            $display("FAIL gap_len: got %0d cycles rn %0d want %0d rn %0d",
                     n, round_num, 1 + GAP_MS * CPM, e_rnd);
            n_err++;
         end
      end
   endtask

   task automatic test_level_reset;
      int n;
      level = 2'd2;
      start = 1'b1; tick; start = 1'b0;
      wait_spawn(1'b0, n);
      tick;
      hit = 1'b1; tick; hit = 1'b0;
      wait_spawn(1'b0, n);
      tick;
      n_cmp++;
      if (score !== 10'd2 || round_active !== 1'b1) begin
         $display("FAIL lr_setup: score %0d ra %0d want 2 1", score, round_active);
         n_err++;
      end
      hit = 1'b1; level_reset = 1'b1;
      tick;
      hit = 1'b0; level_reset = 1'b0;
      n_cmp++;
      if ({state, score, misses, round_num, round_active, time_left_ms} !== '0) begin
         $display("FAIL level_reset_active: state %0d sc %0d mi %0d rn %0d ra %0d tl %0d want all 0",
                  state, score, misses, round_num, round_active, time_left_ms);
         n_err++;
      end
      start = 1'b1; level_reset = 1'b1;
      tick;
      start = 1'b0; level_reset = 1'b0;
      repeat (3) tick;
      n_cmp++;
      if (state !== S_IDLE || time_left_ms !== 12'd0) begin
         $display("FAIL level_reset_vs_start: state %0d tl %0d want %0d 0", state, time_left_ms, S_IDLE);
         n_err++;
      end
   endtask

   task automatic test_rst_gap;
      int n;
      level = 2'd1;
      start = 1'b1; tick; start = 1'b0;
      wait_spawn(1'b0, n);
      tick;
      hit = 1'b1; tick; hit = 1'b0;
      tick;
      n_cmp++;
      if (state !== S_GAP || time_left_ms !== 12'(GAP_MS) || score !== 10'd1) begin
         $display("FAIL gap_entry: state %0d tl %0d sc %0d want %0d %0d 1",
                  state, time_left_ms, score, S_GAP, GAP_MS);
         n_err++;
      end
      tick; tick;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({state, spawn, round_active, game_over, score, misses, round_num, time_left_ms} !== '0) begin
         $display("FAIL rst_mid_gap: outputs %h want 0",
                  {state, spawn, round_active, game_over, score, misses, round_num, time_left_ms});
         n_err++;
      end
      @(negedge clk) rst = 1'b0;
      tick;
      play_game(1, 2, 1'b0, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      play_game(2, 2, 1'b0, 1'b0);
      play_game(3, -2, 1'b0, 1'b0);
      play_game(1, 99, 1'b0, 1'b0);
      play_game(3, 99, 1'b0, 1'b0);
      test_level_reset;
      play_game(1, 1, 1'b1, 1'b0);
      play_game(3, 0, 1'b0, 1'b0);
      play_game(0, -1, 1'b0, 1'b0);
      test_rst_gap;
      for (int i = 0; i < 8; i++)
         play_game(int'($urandom_range(0, 3)), -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
